core_store_buffer: RTL and testbench

Posted-write store buffer between the pipelined core's main-memory port and the backing data memory. Core stores are accepted in one cycle and queued. They drain to memory through a req/ack handshake, so a slow memory never sits in the memory-access stage's path. Core loads check the queued stores and take the youngest matching store's data (forwarding); otherwise they take memory read data.

---
 rtl/core_store_buffer_pkg.sv | 18 +
 rtl/core_store_buffer_match.sv | 33 +++
 rtl/core_store_buffer.sv | 107 ++++++++++
 tb/tb_core_store_buffer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/core_store_buffer_pkg.sv
// Shared types and helpers for the core store buffer.
// Holds the default depth, the entry layout and the pointer-width helper.
package core_store_buffer_pkg;

  localparam int SB_DEPTH_DEFAULT = 4;
  localparam int SB_ADDR_W        = 16;
  localparam int SB_DATA_W        = 16;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;

  function automatic int sb_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/core_store_buffer_match.sv
// Youngest-match search over the store queue, scanning backwards from wr_ptr.
// Returns whether any valid entry holds key_i, and the index of the youngest one.
module sb_match
  import core_store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH_DEFAULT,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int PTR_W  = sb_ptr_w(DEPTH)
) (
  input  logic [ADDR_W-1:0] addr_i [DEPTH],
  input  logic [DEPTH-1:0]  valid_i,
  input  logic [PTR_W-1:0]  wr_ptr_i,
  input  logic [ADDR_W-1:0] key_i,
  output logic              hit_o,
  output logic [PTR_W-1:0]  idx_o
);

  // Oldest slot is visited first, so the last hit written is the youngest.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx   = '0;
    hit_o = 1'b0;
    idx_o = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = wr_ptr_i - PTR_W'(k);
      if (valid_i[idx] && (addr_i[idx] == key_i)) begin
        hit_o = 1'b1;
        idx_o = idx;
      end
    end
  end

endmodule

// File: rtl/core_store_buffer.sv
// Posted-write store buffer with load forwarding between core and data memory.
// Define STORE_BUFFER_COALESCE_EN to merge stores that hit a queued address.
module core_store_buffer
  import core_store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH_DEFAULT,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic              core_we,
  output logic [DATA_W-1:0] core_rdata,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wreq,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_wack,
  output logic              full,
  output logic              empty,
  output logic              overflow
);

  localparam int PTR_W = sb_ptr_w(DEPTH);

  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]    count_q;
  logic              overflow_q;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic [DEPTH-1:0]  valid;
  logic              hit;
  logic [PTR_W-1:0]  hit_idx;
  logic              pop, push, coalesce, drop;

  // An entry is live when its distance from the head is below count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_valid
    localparam logic [PTR_W-1:0] IDX = PTR_W'(i);
    logic [PTR_W-1:0] off;
    assign off      = IDX - rd_ptr_q;
    assign valid[i] = {1'b0, off} < count_q;
  end

  sb_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .PTR_W  (PTR_W)
  ) u_match (
    .addr_i   (addr_q),
    .valid_i  (valid),
    .wr_ptr_i (wr_ptr_q),
    .key_i    (core_addr),
    .hit_o    (hit),
    .idx_o    (hit_idx)
  );

  assign full       = (count_q == (PTR_W+1)'(DEPTH));
  assign empty      = (count_q == '0);
  assign overflow   = overflow_q;
  assign mem_wreq   = !empty;
  assign mem_waddr  = addr_q[rd_ptr_q];
  assign mem_wdata  = data_q[rd_ptr_q];
  assign mem_raddr  = core_addr;
  assign core_rdata = hit ? data_q[hit_idx] : mem_rdata;

  assign pop = mem_wreq && mem_wack;
`ifdef STORE_BUFFER_COALESCE_EN
  // A head entry leaving this cycle cannot absorb the store; it is pushed instead.
  assign coalesce = core_we && hit && !(pop && (hit_idx == rd_ptr_q));
`else
  assign coalesce = 1'b0;
`endif
  assign push = core_we && !coalesce && (!full || pop);
  assign drop = core_we && !coalesce && full && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (push) begin
        addr_q[wr_ptr_q] <= core_addr;
        data_q[wr_ptr_q] <= core_wdata;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (coalesce) data_q[hit_idx] <= core_wdata;
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
      if (drop) overflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_core_store_buffer.sv
// Directed and randomized bench for core_store_buffer against a queue-based model.
module tb_core_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] core_addr = '0;
  logic [15:0] core_wdata = '0;
  logic        core_we = 1'b0;
  logic [15:0] core_rdata;
  logic [15:0] mem_raddr;
  logic [15:0] mem_rdata = '0;
  logic        mem_wreq;
  logic [15:0] mem_waddr;
  logic [15:0] mem_wdata;
  logic        mem_wack = 1'b0;
  logic        full, empty, overflow;

  core_store_buffer dut (
    .clk        (clk),
    .reset      (reset),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_we    (core_we),
    .core_rdata (core_rdata),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .mem_wreq   (mem_wreq),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_wack   (mem_wack),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Model: queue of {addr, data}, oldest at index 0.
  logic [31:0] exp_q[$];
  logic        exp_ovf;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [15:0] exp_rd;
    exp_rd = mem_rdata;
    for (int i = 0; i < exp_q.size(); i++)
      if (exp_q[i][31:16] == core_addr) exp_rd = exp_q[i][15:0];
    chk("core_rdata", {16'h0, core_rdata}, {16'h0, exp_rd});
    chk("mem_raddr", {16'h0, mem_raddr}, {16'h0, core_addr});
    chk("mem_wreq", {31'h0, mem_wreq}, {31'h0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      chk("mem_waddr", {16'h0, mem_waddr}, {16'h0, exp_q[0][31:16]});
      chk("mem_wdata", {16'h0, mem_wdata}, {16'h0, exp_q[0][15:0]});
    end
    chk("full", {31'h0, full}, {31'h0, exp_q.size() == DEPTH});
    chk("empty", {31'h0, empty}, {31'h0, exp_q.size() == 0});
    chk("overflow", {31'h0, overflow}, {31'h0, exp_ovf});
  endtask

  task automatic model_update();
    bit pop, merged;
    pop    = (exp_q.size() != 0) && mem_wack;
    merged = 1'b0;
    if (core_we) begin
`ifdef STORE_BUFFER_COALESCE_EN
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i][31:16] == core_addr) begin
          if (!(pop && i == 0)) begin
            exp_q[i][15:0] = core_wdata;
            merged = 1'b1;
          end
          break;
        end
      end
`endif
    end
    if (pop) void'(exp_q.pop_front());
    if (core_we && !merged) begin
      if (exp_q.size() < DEPTH) exp_q.push_back({core_addr, core_wdata});
      else exp_ovf = 1'b1;
    end
  endtask

  task automatic step(input logic we, input logic [15:0] a, input logic [15:0] wd,
                      input logic ack, input logic [15:0] mr);
    @(negedge clk);
    core_we = we; core_addr = a; core_wdata = wd; mem_wack = ack; mem_rdata = mr;
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; core_we = 1'b0; mem_wack = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
  endtask

  initial begin
    exp_ovf = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();
    chk("rst_waddr", {16'h0, mem_waddr}, 32'h0);
    chk("rst_wdata", {16'h0, mem_wdata}, 32'h0);
    chk("rst_empty", {31'h0, empty}, 32'h1);
    chk("rst_wreq", {31'h0, mem_wreq}, 32'h0);

    // Idle load follows memory.
    step(1'b0, 16'h0000, 16'h0, 1'b0, 16'hBEEF);
    chk("idle_rdata", {16'h0, core_rdata}, 32'hBEEF);

    // Single store, forward, then drain.
    step(1'b1, 16'h0010, 16'h1234, 1'b0, 16'h0000);
    step(1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000);
    step(1'b0, 16'h0010, 16'h0000, 1'b1, 16'h0000);
    #1 chk("drain1_empty", {31'h0, empty}, 32'h1);

    // Fill, overflow, drain in order.
    for (int i = 1; i <= 4; i++) step(1'b1, 16'(i), 16'(i), 1'b0, 16'h0);
    #1 chk("fill_full", {31'h0, full}, 32'h1);
    step(1'b1, 16'h0005, 16'h0005, 1'b0, 16'h0);
    #1 chk("drop_ovf", {31'h0, overflow}, 32'h1);
    chk("drop_full", {31'h0, full}, 32'h1);
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0005, 16'h0, 1'b1, 16'h7777);
    #1 chk("drain4_empty", {31'h0, empty}, 32'h1);

    // Full with simultaneous push and pop: nothing lost, pointers wrap.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 16'h0030 + 16'(i), 16'hC000 + 16'(i), 1'b0, 16'h0);
    step(1'b1, 16'h0040, 16'h4444, 1'b1, 16'h0);
    #1 chk("pp_ovf", {31'h0, overflow}, 32'h0);
    chk("pp_full", {31'h0, full}, 32'h1);
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0040, 16'h0, 1'b1, 16'h0);
    #1 chk("pp_empty", {31'h0, empty}, 32'h1);

    // Same-address stores.
    step(1'b1, 16'h0020, 16'hAAAA, 1'b0, 16'h0);
    step(1'b1, 16'h0020, 16'hBBBB, 1'b0, 16'h0);
    step(1'b0, 16'h0020, 16'h0000, 1'b0, 16'h0);
    chk("dup_fwd", {16'h0, core_rdata}, 32'hBBBB);
    step(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0);
`ifdef STORE_BUFFER_COALESCE_EN
    #1 chk("dup_empty", {31'h0, empty}, 32'h1);
`else
    #1 chk("dup_empty", {31'h0, empty}, 32'h0);
`endif
    step(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0);

    // Randomized traffic over a small address set to exercise hits.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      step($urandom_range(0, 99) < 60, 16'($urandom_range(0, 7)), 16'($urandom),
           $urandom_range(0, 99) < 45, 16'($urandom));
    end

    // Reset while draining discards the queue.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 16'h0050 + 16'(i), 16'h5000 + 16'(i), 1'b0, 16'h0);
    do_reset();
    chk("mid_rst_wreq", {31'h0, mem_wreq}, 32'h0);
    chk("mid_rst_empty", {31'h0, empty}, 32'h1);
    step(1'b0, 16'h0051, 16'h0, 1'b0, 16'h9999);
    chk("mid_rst_rdata", {16'h0, core_rdata}, 32'h9999);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
